// File: rtl/flash_fetch_pkg.sv
// Shared widths and FSM state encoding for the flash sample fetcher.
package flash_fetch_pkg;

  localparam int unsigned FLASH_ADDR_W = 23;
  localparam int unsigned FLASH_DATA_W = 32;
  localparam int unsigned SAMPLE_W     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitData,
    StOutLo,
    StOutHi
  } fetch_state_e;

endpackage

// File: rtl/flash_sample_fetcher.sv
// Streams signed 16-bit samples out of a flash region over Avalon-MM, one
// 32-bit word per read, low half first, cycling through BASE_ADDR..END_ADDR.
// Optional build macro: SAMPLE_ATTEN_EN (arithmetic attenuation by ATTEN_SHIFT).
module flash_sample_fetcher
  import flash_fetch_pkg::*;
#(
  parameter logic [FLASH_ADDR_W-1:0] BASE_ADDR   = 23'd0,
  parameter logic [FLASH_ADDR_W-1:0] END_ADDR    = 23'd127,
  parameter int unsigned             ATTEN_SHIFT = 3
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    play,
  output logic                    flash_mem_read,
  output logic                    flash_mem_write,
  output logic [FLASH_ADDR_W-1:0] flash_mem_address,
  output logic [6:0]              flash_mem_burstcount,
  output logic [3:0]              flash_mem_byteenable,
  output logic [FLASH_DATA_W-1:0] flash_mem_writedata,
  input  logic                    flash_mem_waitrequest,
  input  logic [FLASH_DATA_W-1:0] flash_mem_readdata,
  input  logic                    flash_mem_readdatavalid,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [SAMPLE_W-1:0]     sample_data,
  output logic                    busy,
  output logic                    wrap_pulse
);

  fetch_state_e            state_q, state_d;
  logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
  logic [FLASH_DATA_W-1:0] word_q, word_d;
  logic [SAMPLE_W-1:0]     half;

  assign flash_mem_write      = 1'b0;
  assign flash_mem_burstcount = 7'd1;
  assign flash_mem_byteenable = 4'hF;
  assign flash_mem_writedata  = '0;
  assign flash_mem_address    = addr_q;
  assign busy                 = (state_q != StIdle);

  // State, address counter and captured word.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      addr_q  <= BASE_ADDR;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic and Moore/Mealy outputs.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    word_d         = word_q;
    flash_mem_read = 1'b0;
    sample_valid   = 1'b0;
    wrap_pulse     = 1'b0;
    half           = word_q[SAMPLE_W-1:0];
    unique case (state_q)
      StIdle: begin
        if (play) state_d = StReq;
      end
      StReq: begin
        flash_mem_read = 1'b1;
        if (!flash_mem_waitrequest) state_d = StWaitData;
      end
      StWaitData: begin
        // Only a word returned here is accepted; strays in other states drop.
        if (flash_mem_readdatavalid) begin
          word_d  = flash_mem_readdata;
          state_d = StOutLo;
        end
      end
      StOutLo: begin
        sample_valid = 1'b1;
        if (sample_ready) state_d = StOutHi;
      end
      StOutHi: begin
        sample_valid = 1'b1;
        half         = word_q[FLASH_DATA_W-1:SAMPLE_W];
        if (sample_ready) begin
          if (addr_q == END_ADDR) begin
            addr_d     = BASE_ADDR;
            wrap_pulse = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          state_d = play ? StReq : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SAMPLE_ATTEN_EN
  logic signed [SAMPLE_W-1:0] half_atten;
  assign half_atten  = $signed(half) >>> ATTEN_SHIFT;
  assign sample_data = sample_valid ? half_atten : '0;
`else
  logic unused_atten_shift;
  assign unused_atten_shift = ^ATTEN_SHIFT;
  assign sample_data        = sample_valid ? half : '0;
`endif

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Scoreboard bench: stimulus pushes expected read addresses and samples,
// monitors pop and compare on each accepted read / sample handshake.
module tb_flash_sample_fetcher;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        play;
  logic        flash_mem_read;
  logic        flash_mem_write;
  logic [22:0] flash_mem_address;
  logic [6:0]  flash_mem_burstcount;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_writedata;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_data;
  logic        busy;
  logic        wrap_pulse;

  typedef struct {
    logic [15:0] data;
    logic        wrap;
  } exp_t;

  exp_t        sq[$];
  logic [22:0] aq[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  always #5 clk_clk = ~clk_clk;

  flash_sample_fetcher #(
    .BASE_ADDR  (23'd10),
    .END_ADDR   (23'd11),
    .ATTEN_SHIFT(3)
  ) dut (
    .clk_clk                (clk_clk),
    .reset_reset_n          (reset_reset_n),
    .play                   (play),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_write        (flash_mem_write),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_burstcount   (flash_mem_burstcount),
    .flash_mem_byteenable   (flash_mem_byteenable),
    .flash_mem_writedata    (flash_mem_writedata),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdata     (flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .sample_valid           (sample_valid),
    .sample_ready           (sample_ready),
    .sample_data            (sample_data),
    .busy                   (busy),
    .wrap_pulse             (wrap_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] exp_s(input logic [15:0] h);
    logic signed [15:0] s;
    s = h;
`ifdef SAMPLE_ATTEN_EN
    return s >>> 3;
`else
    return s;
`endif
  endfunction

  // Address monitor: every accepted read must match the next expected address.
  always @(negedge clk_clk) begin
    if (reset_reset_n && flash_mem_read && !flash_mem_waitrequest) begin
      if (aq.size() == 0) check("unexpected_read", flash_mem_address, 23'h7FFFFF);
      else check("read_addr", flash_mem_address, aq.pop_front());
    end
  end

  // Sample monitor: every handshake must match the next expected sample.
  always @(negedge clk_clk) begin
    exp_t e;
    if (reset_reset_n && sample_valid && sample_ready) begin
      if (sq.size() == 0) begin
        check("unexpected_sample", {16'h0, sample_data}, 32'hFFFF_FFFF);
      end else begin
        e = sq.pop_front();
        check("sample_data", {16'h0, sample_data}, {16'h0, e.data});
        check("wrap_pulse", {31'h0, wrap_pulse}, {31'h0, e.wrap});
      end
    end else if (wrap_pulse) begin
      check("wrap_stray", {31'h0, wrap_pulse}, 32'h0);
    end
  end

  // One word transaction: stall the request, return the word, queue expectations.
  task automatic do_word(input logic [31:0] w, input int stall, input logic [22:0] a,
                         input logic wrap, input bit hold_ready, input bit drop_play);
    bit seen = 1'b0;
    aq.push_back(a);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk_clk); #1;
      seen = flash_mem_read;
    end
    check("read_seen", {31'h0, seen}, 32'h1);
    for (int i = 1; i < stall; i++) begin
      @(posedge clk_clk); #1;
      check("req_hold_read", {31'h0, flash_mem_read}, 32'h1);
      check("req_hold_addr", {9'h0, flash_mem_address}, {9'h0, a});
    end
    flash_mem_waitrequest = 1'b0;
    @(posedge clk_clk); #1;
    flash_mem_waitrequest = 1'b1;
    check("wait_read_low", {31'h0, flash_mem_read}, 32'h0);
    @(posedge clk_clk); #1;
    if (drop_play) play = 1'b0;
    if (hold_ready) sample_ready = 1'b0;
    sq.push_back('{data: exp_s(w[15:0]), wrap: 1'b0});
    sq.push_back('{data: exp_s(w[31:16]), wrap: wrap});
    flash_mem_readdata      = w;
    flash_mem_readdatavalid = 1'b1;
    @(posedge clk_clk); #1;
    flash_mem_readdatavalid = 1'b0;
    if (hold_ready) begin
      for (int i = 0; i < 5; i++) begin
        check("stall_valid", {31'h0, sample_valid}, 32'h1);
        check("stall_data", {16'h0, sample_data}, {16'h0, exp_s(w[15:0])});
        check("stall_no_read", {31'h0, flash_mem_read}, 32'h0);
        @(posedge clk_clk); #1;
      end
      sample_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    reset_reset_n           = 1'b0;
    play                    = 1'b0;
    flash_mem_waitrequest   = 1'b1;
    flash_mem_readdata      = '0;
    flash_mem_readdatavalid = 1'b0;
    sample_ready            = 1'b1;
    #12;
    check("rst_read", {31'h0, flash_mem_read}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_data", {16'h0, sample_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_wrap", {31'h0, wrap_pulse}, 32'h0);
    check("rst_addr", {9'h0, flash_mem_address}, 32'd10);
    check("tie_burst", {25'h0, flash_mem_burstcount}, 32'd1);
    check("tie_be", {28'h0, flash_mem_byteenable}, 32'hF);
    check("tie_write", {31'h0, flash_mem_write}, 32'h0);
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    play          = 1'b1;

    do_word(32'h1234_ABCD, 3, 23'd10, 1'b0, 1'b0, 1'b0);
    do_word(32'h5555_0001, 1, 23'd11, 1'b1, 1'b0, 1'b0);
    do_word(32'h1234_ABCD, 2, 23'd10, 1'b0, 1'b1, 1'b0);
    do_word(32'h8000_0010, 1, 23'd11, 1'b1, 1'b0, 1'b1);

    // Play dropped mid-word: both samples land, then the block goes idle.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk_clk); #1;
      ok = !busy;
    end
    check("drop_busy", {31'h0, busy}, 32'h0);
    check("drop_read", {31'h0, flash_mem_read}, 32'h0);
    check("drop_all_samples", sq.size(), 32'd0);
    repeat (3) @(posedge clk_clk);
    #1;
    check("drop_stay_idle", {31'h0, busy}, 32'h0);

    play = 1'b1;
    do_word(32'h00FF_FF00, 1, 23'd10, 1'b0, 1'b0, 1'b0);

    // Reset while the next read (address 11) is stalled.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk_clk); #1;
      ok = flash_mem_read;
    end
    check("pre_rst_read", {31'h0, flash_mem_read}, 32'h1);
    check("pre_rst_addr", {9'h0, flash_mem_address}, 32'd11);
    #2 reset_reset_n = 1'b0;
    #1;
    check("mid_rst_read", {31'h0, flash_mem_read}, 32'h0);
    check("mid_rst_addr", {9'h0, flash_mem_address}, 32'd10);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;
    flash_mem_readdata      = 32'hDEAD_BEEF;
    flash_mem_readdatavalid = 1'b1;
    @(posedge clk_clk); #1;
    @(posedge clk_clk); #1;
    flash_mem_readdatavalid = 1'b0;
    check("stray_no_valid", {31'h0, sample_valid}, 32'h0);
    check("stray_still_req", {31'h0, flash_mem_read}, 32'h1);

    do_word(32'h7FFF_0003, 2, 23'd10, 1'b0, 1'b0, 1'b0);
    play = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk_clk); #1;
      ok = !busy && sq.size() == 0;
    end
    check("end_idle", {31'h0, busy}, 32'h0);
    check("end_samples_drained", sq.size(), 32'd0);
    check("end_reads_drained", aq.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/flash_sample_fetcher.md
FLASH_SAMPLE_FETCHER -- requirements
Module: flash_sample_fetcher

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 23'd0, first 32-bit word address of the sample region.
REQ-002 SHALL have parameter END_ADDR, default 23'd127, last word address of the sample region (inclusive, END_ADDR >= BASE_ADDR).
REQ-003 SHALL have parameter ATTEN_SHIFT, default 3, arithmetic right-shift amount used only under SAMPLE_ATTEN_EN.
REQ-004 SHALL have port clk_clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port play  in  1  level enable for playback.
REQ-007 SHALL have port flash_mem_read  out  1  Avalon-MM read request.
REQ-008 SHALL have port flash_mem_write  out  1  tied 0.
REQ-009 SHALL have port flash_mem_address  out  23  word address.
REQ-010 SHALL have port flash_mem_burstcount  out  7  tied 7'd1.
REQ-011 SHALL have port flash_mem_byteenable  out  4  tied 4'hF.
REQ-012 SHALL have port flash_mem_writedata  out  32  tied 0.
REQ-013 SHALL have port flash_mem_waitrequest  in  1  slave stall.
REQ-014 SHALL have port flash_mem_readdata  in  32  read word, two signed 16-bit samples {hi, lo}.
REQ-015 SHALL have port flash_mem_readdatavalid  in  1  readdata qualifier.
REQ-016 SHALL have port sample_valid  out  1  sample_data valid.
REQ-017 SHALL have port sample_ready  in  1  downstream (codec FIFO) accepts.
REQ-018 SHALL have port sample_data  out  16  signed sample.
REQ-019 SHALL have port busy  out  1  high in any state but IDLE.
REQ-020 SHALL have port wrap_pulse  out  1  one-cycle pulse when address wraps END_ADDR -> BASE_ADDR.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, WAIT_DATA, OUT_LO, OUT_HI.
REQ-022 IDLE -> REQ when play=1; otherwise stay in IDLE.
REQ-023 REQ: flash_mem_read=1 with flash_mem_address=current address; address and read SHALL stay stable while waitrequest=1; go to WAIT_DATA on the first cycle with waitrequest=0.
REQ-024 WAIT_DATA: read=0; on readdatavalid=1, latch readdata into a 32-bit word register and go to OUT_LO.
REQ-025 OUT_LO: sample_valid=1, sample_data=word[15:0]; on sample_ready=1 go to OUT_HI.
REQ-026 OUT_HI: sample_valid=1, sample_data=word[31:16]; on sample_ready=1 advance address, then go to REQ if play=1, else IDLE.
REQ-027 Address advance SHALL be +1, except END_ADDR -> BASE_ADDR with wrap_pulse=1 in that cycle.
REQ-028 sample_data SHALL be stable while sample_valid=1 and sample_ready=0.
REQ-029 play deassert mid-word SHALL NOT abort: the outstanding read completes and both samples are delivered before IDLE.
REQ-030 At most one read outstanding; readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-031 Minimum latency: read issue to sample_valid SHALL be 1 cycle after readdatavalid.

Reset
REQ-032 reset_reset_n=0 SHALL asynchronously force IDLE, address=BASE_ADDR, word=0, flash_mem_read=0, sample_valid=0, sample_data=0, busy=0, wrap_pulse=0.
REQ-033 Reset asserted mid-read SHALL drop flash_mem_read immediately; the late readdatavalid after release SHALL be ignored (per REQ-030).

Configuration
REQ-034 With SAMPLE_ATTEN_EN defined, sample_data SHALL be the sign-preserving arithmetic right shift of the selected half by ATTEN_SHIFT.
REQ-035 Without SAMPLE_ATTEN_EN, sample_data SHALL be the selected half unmodified and ATTEN_SHIFT unused.

Structure
REQ-036 Package flash_fetch_pkg SHALL hold the FSM state enum, FLASH_ADDR_W=23, FLASH_DATA_W=32 and SAMPLE_W=16.
REQ-037 No sub-modules; single module with one FSM and one address counter.

Verification
REQ-038 Reset, play=1, waitrequest high 3 cycles, word 32'h1234_ABCD -> samples 16'hABCD then 16'h1234, address 0 -> 1.
REQ-039 BASE_ADDR=10, END_ADDR=11, play held -> addresses 10,11,10; wrap_pulse exactly once per wrap, on the 11 -> 10 advance.
REQ-040 sample_ready low 5 cycles in OUT_LO -> sample_valid held, sample_data stable at 16'hABCD, no new read.
REQ-041 play dropped during WAIT_DATA -> both samples still delivered, then IDLE, busy=0, read=0.
REQ-042 reset_reset_n pulsed low while read=1 -> read=0 same cycle, address=BASE_ADDR, stray readdatavalid ignored.
REQ-043 SAMPLE_ATTEN_EN, ATTEN_SHIFT=3, word 32'h8000_0010 -> samples 16'h0002 then 16'hF000.
